// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID/EX pipeline stage.
// ALU operation codes, forwarding selects and default widths.
package id_ex_stage_pkg;

  localparam int DW_DEF = 32;
  localparam int RW_DEF = 5;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_SUB   = 4'b0110,
    ALU_SLT   = 4'b0111,
    ALU_RTYPE = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle between decode, the ID/EX register and the hazard sources.
// master drives ID/hazard inputs, slave is the stage itself.
interface id_ex_stage_if
  import id_ex_stage_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
);

  logic          id_valid;
  logic [DW-1:0] id_read_data1;
  logic [DW-1:0] id_read_data2;
  logic [DW-1:0] id_sign_ext_imm;
  logic [5:0]    id_funct;
  logic [3:0]    id_alu_op;
  logic          id_alu_src;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic [RW-1:0] id_rd;
  logic          id_reg_dst;
  logic          id_reg_write;
  logic          id_mem_read;
  logic          id_mem_write;
  logic          id_mem_to_reg;

  logic          branch_flush;
  logic          mem_reg_write;
  logic [RW-1:0] mem_write_reg;
  logic          wb_reg_write;
  logic [RW-1:0] wb_write_reg;

  logic          ex_valid;
  logic [DW-1:0] ex_read_data1;
  logic [DW-1:0] ex_read_data2;
  logic [DW-1:0] ex_sign_ext_imm;
  logic [5:0]    ex_funct;
  logic [3:0]    ex_alu_op;
  logic          ex_alu_src;
  logic [RW-1:0] ex_rs;
  logic [RW-1:0] ex_rt;
  logic [RW-1:0] ex_write_reg;
  logic          ex_reg_write;
  logic          ex_mem_read;
  logic          ex_mem_write;
  logic          ex_mem_to_reg;

  logic [1:0]    ex_forward_a;
  logic [1:0]    ex_forward_b;
  logic          stall;

  modport master (
    output id_valid, id_read_data1, id_read_data2,
    output id_sign_ext_imm, id_funct, id_alu_op,
    output id_alu_src, id_rs, id_rt, id_rd,
    output id_reg_dst, id_reg_write, id_mem_read,
    output id_mem_write, id_mem_to_reg,
    output branch_flush, mem_reg_write,
    output mem_write_reg, wb_reg_write, wb_write_reg,
    input  ex_valid, ex_read_data1, ex_read_data2,
    input  ex_sign_ext_imm, ex_funct, ex_alu_op,
    input  ex_alu_src, ex_rs, ex_rt, ex_write_reg,
    input  ex_reg_write, ex_mem_read, ex_mem_write,
    input  ex_mem_to_reg,
    input  ex_forward_a, ex_forward_b, stall
  );

  modport slave (
    input  id_valid, id_read_data1, id_read_data2,
    input  id_sign_ext_imm, id_funct, id_alu_op,
    input  id_alu_src, id_rs, id_rt, id_rd,
    input  id_reg_dst, id_reg_write, id_mem_read,
    input  id_mem_write, id_mem_to_reg,
    input  branch_flush, mem_reg_write,
    input  mem_write_reg, wb_reg_write, wb_write_reg,
    output ex_valid, ex_read_data1, ex_read_data2,
    output ex_sign_ext_imm, ex_funct, ex_alu_op,
    output ex_alu_src, ex_rs, ex_rt, ex_write_reg,
    output ex_reg_write, ex_mem_read, ex_mem_write,
    output ex_mem_to_reg,
    output ex_forward_a, ex_forward_b, stall
  );

endinterface

// File: rtl/id_ex_stage_forwarding_unit.sv
// Operand bypass select for the EX stage.
// MEM result beats WB data; register 0 is never bypassed.
module forwarding_unit
  import id_ex_stage_pkg::*;
#(
  parameter int RW = RW_DEF
) (
  input  logic          ex_valid_i,
  input  logic [RW-1:0] ex_rs_i,
  input  logic [RW-1:0] ex_rt_i,
  input  logic          mem_reg_write_i,
  input  logic [RW-1:0] mem_write_reg_i,
  input  logic          wb_reg_write_i,
  input  logic [RW-1:0] wb_write_reg_i,
  output fwd_sel_e      fwd_a_o,
  output fwd_sel_e      fwd_b_o
);

  logic mem_a, mem_b;
  logic wb_a, wb_b;
  logic mem_ok, wb_ok;

  assign mem_ok = mem_reg_write_i
                & (mem_write_reg_i != '0);
  assign wb_ok  = wb_reg_write_i
                & (wb_write_reg_i != '0);

  assign mem_a = mem_ok & (mem_write_reg_i == ex_rs_i);
  assign mem_b = mem_ok & (mem_write_reg_i == ex_rt_i);
  assign wb_a  = wb_ok & (wb_write_reg_i == ex_rs_i);
  assign wb_b  = wb_ok & (wb_write_reg_i == ex_rt_i);

  always_comb begin
    fwd_a_o = FWD_REG;
    if (ex_valid_i) begin
      if (mem_a)     fwd_a_o = FWD_MEM;
      else if (wb_a) fwd_a_o = FWD_WB;
    end
  end

  always_comb begin
    fwd_b_o = FWD_REG;
    if (ex_valid_i) begin
      if (mem_b)     fwd_b_o = FWD_MEM;
      else if (wb_b) fwd_b_o = FWD_WB;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and flush bubble.
// Bypass selects come from the forwarding_unit sub-block.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic         clk,
  input  logic         reset,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] imm;
    logic [5:0]    funct;
    logic [3:0]    alu_op;
    logic          alu_src;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] wr;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          mem_to_reg;
  } id_ex_t;

  id_ex_t   ex_q, ex_d, cap;
  logic     lu, hit, bubble;
  fwd_sel_e fwd_a, fwd_b;

  assign hit = (ex_q.wr == bus.id_rs)
             | (ex_q.wr == bus.id_rt);

  assign lu = ex_q.valid & ex_q.mem_read
            & (ex_q.wr != '0) & hit
            & bus.id_valid;

  // A flush already inserts the bubble, so no stall.
  assign bus.stall = lu & ~bus.branch_flush & ~reset;
  assign bubble    = lu | bus.branch_flush;

  always_comb begin
    cap            = '0;
    cap.valid      = bus.id_valid;
    cap.rd1        = bus.id_read_data1;
    cap.rd2        = bus.id_read_data2;
    cap.imm        = bus.id_sign_ext_imm;
    cap.funct      = bus.id_funct;
    cap.alu_op     = bus.id_alu_op;
    cap.alu_src    = bus.id_alu_src;
    cap.rs         = bus.id_rs;
    cap.rt         = bus.id_rt;
    cap.wr         = bus.id_reg_dst ? bus.id_rd
                                    : bus.id_rt;
    cap.reg_write  = bus.id_reg_write;
    cap.mem_read   = bus.id_mem_read;
    cap.mem_write  = bus.id_mem_write;
    cap.mem_to_reg = bus.id_mem_to_reg;
  end

  always_comb begin
    ex_d = cap;
    if (bubble) ex_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  assign bus.ex_valid        = ex_q.valid;
  assign bus.ex_read_data1   = ex_q.rd1;
  assign bus.ex_read_data2   = ex_q.rd2;
  assign bus.ex_sign_ext_imm = ex_q.imm;
  assign bus.ex_funct        = ex_q.funct;
  assign bus.ex_alu_op       = ex_q.alu_op;
  assign bus.ex_alu_src      = ex_q.alu_src;
  assign bus.ex_rs           = ex_q.rs;
  assign bus.ex_rt           = ex_q.rt;
  assign bus.ex_write_reg    = ex_q.wr;
  assign bus.ex_reg_write    = ex_q.reg_write;
  assign bus.ex_mem_read     = ex_q.mem_read;
  assign bus.ex_mem_write    = ex_q.mem_write;
  assign bus.ex_mem_to_reg   = ex_q.mem_to_reg;

  forwarding_unit #(.RW(RW)) u_fwd (
    .ex_valid_i      (ex_q.valid & ~reset),
    .ex_rs_i         (ex_q.rs),
    .ex_rt_i         (ex_q.rt),
    .mem_reg_write_i (bus.mem_reg_write),
    .mem_write_reg_i (bus.mem_write_reg),
    .wb_reg_write_i  (bus.wb_reg_write),
    .wb_write_reg_i  (bus.wb_write_reg),
    .fwd_a_o         (fwd_a),
    .fwd_b_o         (fwd_b)
  );

  assign bus.ex_forward_a = fwd_a;
  assign bus.ex_forward_b = fwd_b;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: capture, load-use,
// forwarding priority, flush vs stall and async reset.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  id_ex_stage_if #(.DW(32), .RW(5)) bus ();

  id_ex_stage #(.DW(32), .RW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic clear_id();
    bus.id_valid        = 1'b0;
    bus.id_read_data1   = '0;
    bus.id_read_data2   = '0;
    bus.id_sign_ext_imm = '0;
    bus.id_funct        = '0;
    bus.id_alu_op       = '0;
    bus.id_alu_src      = 1'b0;
    bus.id_rs           = '0;
    bus.id_rt           = '0;
    bus.id_rd           = '0;
    bus.id_reg_dst      = 1'b0;
    bus.id_reg_write    = 1'b0;
    bus.id_mem_read     = 1'b0;
    bus.id_mem_write    = 1'b0;
    bus.id_mem_to_reg   = 1'b0;
    bus.branch_flush    = 1'b0;
    bus.mem_reg_write   = 1'b0;
    bus.mem_write_reg   = '0;
    bus.wb_reg_write    = 1'b0;
    bus.wb_write_reg    = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_id();
    bus.id_valid     = 1'b1;
    bus.id_reg_write = 1'b1;
    bus.id_rt        = 5'd3;
    tick();
    checks++;
    if (bus.ex_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid: got %0h want 0", bus.ex_valid);
    end
    checks++;
    if (bus.ex_reg_write !== 1'b0) begin
      errors++;
      $display("FAIL rst_reg_write: got %0h want 0", bus.ex_reg_write);
    end
    checks++;
    if (bus.ex_write_reg !== 5'd0) begin
      errors++;
      $display("FAIL rst_write_reg: got %0h want 0", bus.ex_write_reg);
    end
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_stall: got %0h want 0", bus.stall);
    end
    checks++;
    if (bus.ex_forward_a !== 2'b00) begin
      errors++;
      $display("FAIL rst_fwd_a: got %0b want 00", bus.ex_forward_a);
    end
    reset = 1'b0;
    clear_id();
  endtask

  task automatic test_capture();
    clear_id();
    bus.id_valid      = 1'b1;
    bus.id_rs         = 5'd2;
    bus.id_rt         = 5'd3;
    bus.id_rd         = 5'd4;
    bus.id_reg_dst    = 1'b1;
    bus.id_read_data1 = 32'h10;
    bus.id_alu_op     = 4'b1111;
    bus.id_funct      = 6'b100000;
    tick();
    checks++;
    if (bus.ex_write_reg !== 5'd4) begin
      errors++;
      $display("FAIL cap_write_reg: got %0d want 4", bus.ex_write_reg);
    end
    checks++;
    if (bus.ex_read_data1 !== 32'h10) begin
      errors++;
      $display("FAIL cap_rd1: got %0h want 10", bus.ex_read_data1);
    end
    checks++;
    if (bus.ex_alu_op !== 4'b1111) begin
      errors++;
      $display("FAIL cap_alu_op: got %0b want 1111", bus.ex_alu_op);
    end
    checks++;
    if (bus.ex_valid !== 1'b1) begin
      errors++;
      $display("FAIL cap_valid: got %0h want 1", bus.ex_valid);
    end
    checks++;
    if (bus.ex_funct !== 6'b100000) begin
      errors++;
      $display("FAIL cap_funct: got %0b want 100000", bus.ex_funct);
    end
    checks++;
    if (bus.ex_rs !== 5'd2 || bus.ex_rt !== 5'd3) begin
      errors++;
      $display("FAIL cap_rs_rt: got %0d/%0d want 2/3", bus.ex_rs, bus.ex_rt);
    end
    bus.id_reg_dst = 1'b0;
    tick();
    checks++;
    if (bus.ex_write_reg !== 5'd3) begin
      errors++;
      $display("FAIL cap_rt_dst: got %0d want 3", bus.ex_write_reg);
    end
    clear_id();
  endtask

  task automatic test_load_use();
    clear_id();
    bus.id_valid      = 1'b1;
    bus.id_mem_read   = 1'b1;
    bus.id_reg_write  = 1'b1;
    bus.id_mem_to_reg = 1'b1;
    bus.id_rs         = 5'd1;
    bus.id_rt         = 5'd5;
    tick();
    clear_id();
    bus.id_valid     = 1'b1;
    bus.id_rs        = 5'd5;
    bus.id_rt        = 5'd6;
    bus.id_rd        = 5'd7;
    bus.id_reg_dst   = 1'b1;
    bus.id_reg_write = 1'b1;
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin
      errors++;
      $display("FAIL lu_stall: got %0h want 1", bus.stall);
    end
    tick();
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.ex_mem_read !== 1'b0) begin
      errors++;
      $display("FAIL lu_bubble: got v=%0h mr=%0h want 0/0", bus.ex_valid, bus.ex_mem_read);
    end
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL lu_release: got %0h want 0", bus.stall);
    end
    tick();
    checks++;
    if (bus.ex_valid !== 1'b1 || bus.ex_write_reg !== 5'd7) begin
      errors++;
      $display("FAIL lu_recap: got v=%0h wr=%0d want 1/7", bus.ex_valid, bus.ex_write_reg);
    end
    clear_id();
    bus.id_valid    = 1'b1;
    bus.id_mem_read = 1'b1;
    bus.id_rt       = 5'd8;
    tick();
    clear_id();
    bus.id_valid = 1'b1;
    bus.id_rt    = 5'd8;
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin
      errors++;
      $display("FAIL lu_rt_stall: got %0h want 1", bus.stall);
    end
    bus.id_valid = 1'b0;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL lu_id_invalid: got %0h want 0", bus.stall);
    end
    tick();
    clear_id();
    bus.id_valid    = 1'b1;
    bus.id_mem_read = 1'b1;
    bus.id_rt       = 5'd0;
    tick();
    clear_id();
    bus.id_valid = 1'b1;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL lu_reg0: got %0h want 0", bus.stall);
    end
    clear_id();
    tick();
  endtask

  task automatic test_forward();
    clear_id();
    bus.id_valid = 1'b1;
    bus.id_rs    = 5'd7;
    bus.id_rt    = 5'd0;
    tick();
    bus.mem_reg_write = 1'b1;
    bus.mem_write_reg = 5'd7;
    bus.wb_reg_write  = 1'b1;
    bus.wb_write_reg  = 5'd7;
    #1;
    checks++;
    if (bus.ex_forward_a !== 2'b10) begin
      errors++;
      $display("FAIL fwd_mem_prio: got %0b want 10", bus.ex_forward_a);
    end
    checks++;
    if (bus.ex_forward_b !== 2'b00) begin
      errors++;
      $display("FAIL fwd_rt0: got %0b want 00", bus.ex_forward_b);
    end
    bus.mem_reg_write = 1'b0;
    #1;
    checks++;
    if (bus.ex_forward_a !== 2'b01) begin
      errors++;
      $display("FAIL fwd_wb: got %0b want 01", bus.ex_forward_a);
    end
    bus.id_rs = 5'd3;
    bus.id_rt = 5'd9;
    tick();
    bus.mem_reg_write = 1'b1;
    bus.mem_write_reg = 5'd9;
    bus.wb_reg_write  = 1'b1;
    bus.wb_write_reg  = 5'd3;
    #1;
    checks++;
    if (bus.ex_forward_a !== 2'b01 || bus.ex_forward_b !== 2'b10) begin
      errors++;
      $display("FAIL fwd_split: got %0b/%0b want 01/10", bus.ex_forward_a, bus.ex_forward_b);
    end
    bus.id_valid = 1'b0;
    tick();
    checks++;
    if (bus.ex_forward_a !== 2'b00 || bus.ex_forward_b !== 2'b00) begin
      errors++;
      $display("FAIL fwd_invalid: got %0b/%0b want 00/00", bus.ex_forward_a, bus.ex_forward_b);
    end
    clear_id();
  endtask

  task automatic test_flush_stall();
    clear_id();
    bus.id_valid     = 1'b1;
    bus.id_mem_read  = 1'b1;
    bus.id_reg_write = 1'b1;
    bus.id_rt        = 5'd5;
    tick();
    clear_id();
    bus.id_valid      = 1'b1;
    bus.id_rs         = 5'd5;
    bus.id_rd         = 5'd4;
    bus.id_reg_dst    = 1'b1;
    bus.id_reg_write  = 1'b1;
    bus.id_read_data1 = 32'h55;
    bus.id_alu_op     = 4'b0010;
    bus.branch_flush  = 1'b1;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL fl_stall: got %0h want 0", bus.stall);
    end
    tick();
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0 || bus.ex_mem_read !== 1'b0) begin
      errors++;
      $display("FAIL fl_ctrl: got v=%0h rw=%0h mr=%0h want 0", bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read);
    end
    checks++;
    if (bus.ex_rs !== 5'd0 || bus.ex_write_reg !== 5'd0) begin
      errors++;
      $display("FAIL fl_regs: got rs=%0d wr=%0d want 0", bus.ex_rs, bus.ex_write_reg);
    end
    checks++;
    if (bus.ex_read_data1 !== 32'h0 || bus.ex_alu_op !== 4'b0000) begin
      errors++;
      $display("FAIL fl_data: got %0h/%0b want 0/0000", bus.ex_read_data1, bus.ex_alu_op);
    end
    bus.branch_flush = 1'b0;
    tick();
    checks++;
    if (bus.ex_valid !== 1'b1 || bus.ex_write_reg !== 5'd4) begin
      errors++;
      $display("FAIL fl_recap: got v=%0h wr=%0d want 1/4", bus.ex_valid, bus.ex_write_reg);
    end
    clear_id();
  endtask

  task automatic test_async_reset();
    clear_id();
    bus.id_valid     = 1'b1;
    bus.id_rs        = 5'd7;
    bus.id_rt        = 5'd2;
    bus.id_reg_write = 1'b1;
    tick();
    bus.mem_reg_write = 1'b1;
    bus.mem_write_reg = 5'd7;
    #1;
    checks++;
    if (bus.ex_reg_write !== 1'b1 || bus.ex_forward_a !== 2'b10) begin
      errors++;
      $display("FAIL ar_pre: got rw=%0h fa=%0b want 1/10", bus.ex_reg_write, bus.ex_forward_a);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.ex_reg_write !== 1'b0) begin
      errors++;
      $display("FAIL ar_reg_write: got %0h want 0", bus.ex_reg_write);
    end
    checks++;
    if (bus.ex_forward_a !== 2'b00 || bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL ar_comb: got fa=%0b st=%0h want 00/0", bus.ex_forward_a, bus.stall);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.ex_valid !== 1'b1 || bus.ex_reg_write !== 1'b1) begin
      errors++;
      $display("FAIL ar_release: got v=%0h rw=%0h want 1/1", bus.ex_valid, bus.ex_reg_write);
    end
    clear_id();
  endtask

  initial begin
    reset = 1'b1;
    clear_id();
    test_reset();
    test_capture();
    test_load_use();
    test_forward();
    test_flush_stall();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
